vec_seq: RTL and testbench
==========================

// Module: vec_seq
// PURPOSE
//  Synthesizable test-vector sequencer for emulator firmware. Stores up to N_VEC
//  {a, b, mode, expct} vectors and drives them onto the DUT operand/mode inputs.
//  Samples the DUT result c_out after a settle window and keeps pass/fail statistics.
//  Sits directly upstream of the arithmetic DUT and consumes its c_out.
// PARAMETERS
//  N_VEC       16   vector table depth
//  DATA_W      8    width of a, b, mode, expct, c_out
//  SETTLE_CYC  10   cycles from operand update to c_out sample (>=1)
//  HOLD_CYC    10   idle cycles after sample before next vector (>=0)
//  CNT_W       16   width of pass/fail counters
// PORTS
//  emu_clk         in   1            single clock; all logic rising-edge
//  emu_rst         in   1            synchronous, active-high reset
//  start           in   1            1-cycle pulse: begin run (ignored while busy)
//  num_vec         in   clog2(N_VEC+1)  vectors to run; sampled on start; >N_VEC saturates to N_VEC
//  wr_en           in   1            vector table write strobe (ignored while busy)
//  wr_addr         in   clog2(N_VEC) table index
//  wr_data         in   4*DATA_W     {a, b, mode, expct}, a in MSBs
//  a_in/b_in       out  DATA_W       DUT operands (registered)
//  mode_in         out  DATA_W       DUT mode (registered)
//  c_out           in   DATA_W       DUT result
//  busy            out  1            run in progress
//  done            out  1            run finished; held until next start or reset
//  err_pulse       out  1            1-cycle pulse on each mismatch
//  pass_cnt        out  CNT_W        matching vectors, saturating
//  fail_cnt        out  CNT_W        mismatching vectors, saturating
//  first_fail_idx  out  clog2(N_VEC)+1  index of first mismatch; all-ones = none
// BEHAVIOUR
//  - Reset: a_in=b_in=mode_in=0, busy=0, done=0, err_pulse=0, counters=0, first_fail_idx=all-ones, FSM=IDLE.
//  - Reset does not clear the vector table. Reset mid-run aborts immediately; no done pulse.
//  - FSM: IDLE -start-> (num_vec==0 ? DONE : APPLY) -> SETTLE -> CHECK -> HOLD -> APPLY|DONE.
//  - On accepted start: clear counters, set first_fail_idx=all-ones, clear done, idx=0, busy=1.
//  - APPLY: 1 cycle. Issues synchronous table read at idx. Registers a_in/b_in/mode_in/expct_q at cycle end.
//  - SETTLE: exactly SETTLE_CYC cycles.
//  - CHECK: 1 cycle. Compares c_out==expct_q (all DATA_W bits).
//    - Match: pass_cnt++.
//    - Mismatch: fail_cnt++, err_pulse=1 next cycle, first_fail_idx=idx if still all-ones.
//  - HOLD: HOLD_CYC cycles (0 = skip). Then idx++; if idx==num_vec go to DONE, else APPLY.
//  - Per-vector period = SETTLE_CYC+HOLD_CYC+2 cycles.
//  - DONE: busy=0, done=1. Operands keep last vector. Table writes allowed. Next start restarts from IDLE behaviour.
//  - start in the same cycle as wr_en: the write completes first; the run sees the new data.
//  - Counters saturate at 2^CNT_W-1; no wrap.
// CONFIGURATION
//  VEC_SEQ_STOP_ON_FAIL_EN defined: first mismatch goes CHECK->DONE, skipping HOLD and remaining vectors.
//  Undefined: all num_vec vectors always run.
// STRUCTURE
//  vec_seq_pkg: state_t enum (IDLE, APPLY, SETTLE, CHECK, HOLD, DONE),
//    vec_t packed struct {a, b, mode, expct}, VEC_NONE all-ones constant function.
//  Sub-module vec_seq_mem: N_VEC x vec_t register file, 1 write port, 1 sync read port.
// TESTING  (bench DUT model: mode0 c=a+b, mode1 c=a-b, mode3 c=a*b, mode5 c=a<<b)
//  1. Load (12,34,0,46),(45,10,1,35),(3,7,3,21); num_vec=3; start
//     -> pass=3, fail=0, first_fail_idx=all-ones; done at 3*22 cycles after start+IDLE.
//  2. Load (9,1,5,99) at idx 1 among passing vectors; num_vec=3
//     -> fail=1, first_fail_idx=1, exactly one err_pulse, pass=2.
//  3. num_vec=0, start -> done=1 within 2 cycles, counters 0, operands unchanged.
//  4. Assert emu_rst during SETTLE of vector 1 -> all outputs at reset values next cycle.
//     Rerun without reloading -> same results as the uninterrupted run.
//  5. start and wr_en pulsed while busy -> ignored. Counts unchanged, table unchanged.
//  6. Build with VEC_SEQ_STOP_ON_FAIL_EN, mismatch at idx 0 of 3
//     -> done after 1+SETTLE_CYC+1 cycles, fail=1, pass=0.

Source files
------------

// File: rtl/vec_seq_pkg.sv
// Shared types for the vec_seq test-vector sequencer: FSM states, vector layout, "no index" value.
package vec_seq_pkg;

    localparam int unsigned VEC_DW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCheck,
        StHold,
        StDone
    } state_t;

    typedef struct packed {
        logic [VEC_DW-1:0] a;
        logic [VEC_DW-1:0] b;
        logic [VEC_DW-1:0] mode;
        logic [VEC_DW-1:0] expct;
    } vec_t;

    // All-ones value of width w, used as the "no failure seen" marker.
    function automatic int unsigned vec_none(int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/vec_seq_mem.sv
// Vector table: DEPTH x WIDTH register file, one write port, one synchronous read port.
module vec_seq_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] table_q [DEPTH];

    // Table contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= table_q[rd_addr];
        end
    end

endmodule

// File: rtl/vec_seq.sv
// Test-vector sequencer: drives stored vectors onto a DUT and scores its c_out.
// Define VEC_SEQ_STOP_ON_FAIL_EN to end a run at the first mismatch.
module vec_seq
    import vec_seq_pkg::*;
#(
    parameter int unsigned N_VEC      = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SETTLE_CYC = 10,
    parameter int unsigned HOLD_CYC   = 10,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         emu_clk,
    input  logic                         emu_rst,
    input  logic                         start,
    input  logic [$clog2(N_VEC+1)-1:0]   num_vec,
    input  logic                         wr_en,
    input  logic [$clog2(N_VEC)-1:0]     wr_addr,
    input  logic [4*DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]            a_in,
    output logic [DATA_W-1:0]            b_in,
    output logic [DATA_W-1:0]            mode_in,
    input  logic [DATA_W-1:0]            c_out,
    output logic                         busy,
    output logic                         done,
    output logic                         err_pulse,
    output logic [CNT_W-1:0]             pass_cnt,
    output logic [CNT_W-1:0]             fail_cnt,
    output logic [$clog2(N_VEC):0]       first_fail_idx
);

    localparam int unsigned NV_W    = $clog2(N_VEC + 1);
    localparam int unsigned ADDR_W  = $clog2(N_VEC);
    localparam int unsigned IDX_W   = ADDR_W + 1;
    localparam int unsigned CYC_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int unsigned CYC_W   = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX + 1);
    localparam int unsigned HOLD_LD = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

    localparam logic [CYC_W-1:0] SETTLE_LOAD = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] HOLD_LOAD   = CYC_W'(HOLD_LD);
    localparam logic [IDX_W-1:0] IDX_NONE    = IDX_W'(vec_none(IDX_W));

`ifdef VEC_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t              state_q;
    logic [CYC_W-1:0]    cnt_q;
    logic [NV_W-1:0]     idx_q;
    logic [NV_W-1:0]     num_q;
    logic [NV_W-1:0]     idx_next;
    logic [NV_W-1:0]     num_sat;
    logic                last_vec;
    logic                mismatch;
    logic [4*DATA_W-1:0] rd_vec;
    logic [DATA_W-1:0]   expct;

    // The table read register doubles as the operand register, so operands update only in APPLY.
    vec_seq_mem #(
        .DEPTH  (N_VEC),
        .WIDTH  (4 * DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (emu_clk),
        .rst     (emu_rst),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state_q == StApply),
        .rd_addr (idx_q[ADDR_W-1:0]),
        .rd_data (rd_vec)
    );

    assign a_in    = rd_vec[4*DATA_W-1 -: DATA_W];
    assign b_in    = rd_vec[3*DATA_W-1 -: DATA_W];
    assign mode_in = rd_vec[2*DATA_W-1 -: DATA_W];
    assign expct   = rd_vec[DATA_W-1:0];

    always_comb begin
        num_sat  = (num_vec > NV_W'(N_VEC)) ? NV_W'(N_VEC) : num_vec;
        idx_next = idx_q + NV_W'(1);
        last_vec = (idx_next == num_q);
        mismatch = (c_out != expct);
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            idx_q          <= '0;
            num_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_pulse      <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= IDX_NONE;
        end else begin
            err_pulse <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= IDX_NONE;
                        idx_q          <= '0;
                        num_q          <= num_sat;
                        if (num_sat == '0) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StApply;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end
                StApply: begin
                    state_q <= StSettle;
                    cnt_q   <= SETTLE_LOAD;
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_q <= StCheck;
                    end else begin
                        cnt_q <= cnt_q - CYC_W'(1);
                    end
                end
                StCheck: begin
                    if (!mismatch) begin
                        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                        err_pulse <= 1'b1;
                        if (first_fail_idx == IDX_NONE) first_fail_idx <= IDX_W'(idx_q);
                    end
                    if (STOP_ON_FAIL && mismatch) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (HOLD_CYC > 0) begin
                        state_q <= StHold;
                        cnt_q   <= HOLD_LOAD;
                    end else if (last_vec) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        idx_q   <= idx_next;
                        state_q <= StApply;
                    end
                end
                StHold: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CYC_W'(1);
                    end else if (last_vec) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        idx_q   <= idx_next;
                        state_q <= StApply;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_seq.sv
// Self-checking bench for vec_seq: directed scenarios plus randomized tables against a run model.
module tb_vec_seq;
    import vec_seq_pkg::*;

    localparam int unsigned SETTLE = 10;
    localparam int unsigned HOLD   = 10;
    localparam int unsigned PERIOD = SETTLE + HOLD + 2;
    localparam int          BUDGET = 1000;

    logic        emu_clk = 1'b0;
    logic        emu_rst;
    logic        start;
    logic [4:0]  num_vec;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  a_in, b_in, mode_in, c_out;
    logic        busy, done, err_pulse;
    logic [15:0] pass_cnt, fail_cnt;
    logic [4:0]  first_fail_idx;

    vec_t tbl [16];
    logic [7:0] m_a, m_b, m_mode;
    int e_pass, e_fail, e_ffi, e_lat;
    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;

    vec_seq #(
        .N_VEC      (16),
        .DATA_W     (8),
        .SETTLE_CYC (SETTLE),
        .HOLD_CYC   (HOLD),
        .CNT_W      (16)
    ) dut (
        .emu_clk        (emu_clk),
        .emu_rst        (emu_rst),
        .start          (start),
        .num_vec        (num_vec),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .a_in           (a_in),
        .b_in           (b_in),
        .mode_in        (mode_in),
        .c_out          (c_out),
        .busy           (busy),
        .done           (done),
        .err_pulse      (err_pulse),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx)
    );

    always #5 emu_clk = ~emu_clk;

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] mode);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (mode)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd3:    return p[7:0];
            8'd5:    return a << b;
            default: return 8'd0;
        endcase
    endfunction

    always_comb c_out = ref_op(a_in, b_in, mode_in);

    // Value seen during the cycle before each edge, so a pulse coinciding with done still counts.
    always @(posedge emu_clk) if (err_pulse === 1'b1) err_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic vec_t mk(input int a, input int b, input int m, input int e);
        vec_t v;
        v.a = 8'(a); v.b = 8'(b); v.mode = 8'(m); v.expct = 8'(e);
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        int sel;
        sel = $urandom_range(0, 3);
        v.mode = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'd3 : 8'd5;
        v.a = 8'($urandom);
        v.b = (v.mode == 8'd5) ? 8'($urandom_range(0, 9)) : 8'($urandom);
        v.expct = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ref_op(v.a, v.b, v.mode);
        return v;
    endfunction

    // Called right after a negedge while the sequencer is idle.
    task automatic write_vec(input int addr, input vec_t v);
        wr_en = 1'b1; wr_addr = 4'(addr); wr_data = v;
        @(negedge emu_clk);
        wr_en = 1'b0;
        tbl[addr] = v;
    endtask

    // Predict the run from the table contents, then pulse start (optionally with a write).
    task automatic launch(input logic [4:0] nv, input bit do_wr, input int wa, input vec_t wv);
        int n;
        bit stop;
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = 4'(wa); wr_data = wv;
            tbl[wa] = wv;
        end
        n = (nv > 5'd16) ? 16 : int'(nv);
        e_pass = 0; e_fail = 0; e_ffi = 31; e_lat = n * PERIOD; stop = 1'b0;
        for (int i = 0; i < n && !stop; i++) begin
            m_a = tbl[i].a; m_b = tbl[i].b; m_mode = tbl[i].mode;
            if (ref_op(tbl[i].a, tbl[i].b, tbl[i].mode) == tbl[i].expct) begin
                e_pass++;
            end else begin
                e_fail++;
                if (e_ffi == 31) e_ffi = i;
`ifdef VEC_SEQ_STOP_ON_FAIL_EN
                stop = 1'b1;
                e_lat = i * PERIOD + SETTLE + 2;
`endif
            end
        end
        err_seen = 0;
        num_vec = nv;
        start = 1'b1;
        @(negedge emu_clk);
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int pre);
        int lat;
        lat = pre;
        while (done !== 1'b1 && lat < BUDGET) begin
            @(negedge emu_clk);
            lat++;
        end
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".pass"}, pass_cnt, e_pass);
        check({tag, ".fail"}, fail_cnt, e_fail);
        check({tag, ".ffi"}, first_fail_idx, e_ffi);
        check({tag, ".ops"}, {a_in, b_in, mode_in}, {m_a, m_b, m_mode});
        @(posedge emu_clk);
        #1;
        check({tag, ".err_pulses"}, err_seen, e_fail);
        @(negedge emu_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ops"}, {a_in, b_in, mode_in}, 0);
        check({tag, ".flags"}, {busy, done, err_pulse}, 0);
        check({tag, ".pass"}, pass_cnt, 0);
        check({tag, ".fail"}, fail_cnt, 0);
        check({tag, ".ffi"}, first_fail_idx, 31);
    endtask

    initial begin
        vec_t bad;
        bit any_done;
        int r;
        logic [4:0] nv;

        emu_rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_vec = '0;
        m_a = 0; m_b = 0; m_mode = 0;
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        repeat (3) @(negedge emu_clk);
        check_reset_outputs("reset");
        emu_rst = 1'b0;
        // Define the whole table so the model matches whatever the DUT holds.
        for (int i = 0; i < 16; i++) write_vec(i, mk(0, 0, 0, 0));

        // Three passing vectors.
        write_vec(0, mk(12, 34, 0, 46));
        write_vec(1, mk(45, 10, 1, 35));
        write_vec(2, mk(3, 7, 3, 21));
        launch(5'd3, 1'b0, 0, '0);
        finish_run("pass3", 0);

        // Mismatch in the middle vector.
        write_vec(1, mk(9, 1, 5, 99));
        launch(5'd3, 1'b0, 0, '0);
        finish_run("mid_fail", 0);

        // Empty run: immediate done, operands untouched.
        launch(5'd0, 1'b0, 0, '0);
        finish_run("empty", 0);

        // Reset while vector 1 is settling, then rerun the same table.
        write_vec(1, mk(45, 10, 1, 35));
        launch(5'd3, 1'b0, 0, '0);
        repeat (24) @(negedge emu_clk);
        emu_rst = 1'b1;
        @(negedge emu_clk);
        check_reset_outputs("midrun_rst");
        emu_rst = 1'b0;
        m_a = 0; m_b = 0; m_mode = 0;
        any_done = 1'b0;
        repeat (30) begin
            @(negedge emu_clk);
            any_done |= done;
        end
        check("midrun_rst.no_done", any_done, 0);
        launch(5'd3, 1'b0, 0, '0);
        finish_run("rerun", 0);

        // start/wr_en while busy are ignored; a second run proves the table is intact.
        bad = mk(1, 1, 0, 77);
        launch(5'd3, 1'b0, 0, '0);
        repeat (5) @(negedge emu_clk);
        check("busy_mid", busy, 1);
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = bad; num_vec = 5'd1;
        @(negedge emu_clk);
        start = 1'b0; wr_en = 1'b0;
        finish_run("busy_ignore", 6);
        launch(5'd3, 1'b0, 0, '0);
        finish_run("table_intact", 0);

        // Write and start in the same cycle: the run sees the new vector.
        launch(5'd2, 1'b1, 1, mk(5, 6, 3, 31));
        finish_run("wr_and_start", 0);

        // Randomized tables and lengths, including 0 and saturating lengths.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) write_vec(i, rnd_vec());
            r = $urandom_range(0, 5);
            nv = (t == 0) ? 5'd31 : (t == 1) ? 5'd17 : (r == 0) ? 5'd0
                 : 5'($urandom_range(1, 16));
            launch(nv, 1'b0, 0, '0);
            finish_run($sformatf("rand%0d", t), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
